// File: rtl/seq_decoder_pkg.sv
// Shared definitions for the registered one-hot decoder: FSM state encoding
// and the one-hot helper used for direct-mode decodes and scan entry.
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } dec_state_t;

  // Widest select supported; callers cast the result down to their own 2**SEL_W.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx);
    return MAX_OUT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/seq_decoder_scan_prescaler.sv
// Free-running divide-by-DIV counter; step is high on the last count of each
// period while enabled. clear forces the count back to the start of a period.
module scan_prescaler
  import seq_decoder_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic step
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign step = en & ~clear & (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seq_decoder_scan.sv
// Registered SEL_W-to-2**SEL_W decoder with timed direct decodes and a scan
// mode. Define SEQ_DECODER_ACTIVE_LOW_EN to drive dec_out active-low.
module seq_decoder_scan
  import seq_decoder_pkg::*;
#(
  parameter  int SEL_W    = 3,
  parameter  int HOLD_CYC = 2,
  parameter  int SCAN_DIV = 4,
  localparam int OUT_W    = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] dec_out,
  output logic             out_valid,
  output logic [SEL_W-1:0] cur_idx,
  output logic             wrap
);

  localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  dec_state_t       state_reg, state_next;
  logic [OUT_W-1:0] dec_reg, dec_next;
  logic             valid_reg, valid_next;
  logic [SEL_W-1:0] idx_reg, idx_next;
  logic [HC_W-1:0]  hold_reg, hold_next;
  logic             wrap_reg, wrap_next;
  logic             pre_en, pre_clear, pre_step;
  logic             handshake;

  assign in_ready  = (state_reg == IDLE) & en & ~mode & ~rst;
  assign handshake = in_valid & in_ready;

  scan_prescaler #(
    .DIV(SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clear(pre_clear),
    .step (pre_step)
  );

  always_comb begin
    state_next = state_reg;
    dec_next   = dec_reg;
    valid_next = valid_reg;
    idx_next   = idx_reg;
    hold_next  = hold_reg;
    wrap_next  = 1'b0;
    pre_en     = 1'b0;
    pre_clear  = 1'b0;

    case (state_reg)
      IDLE: begin
        // Prescaler sits at zero so scan entry always starts a full period.
        pre_clear = 1'b1;
        if (en && mode) begin
          state_next = SCAN;
          dec_next   = OUT_W'(onehot(0));
          valid_next = 1'b1;
          idx_next   = '0;
        end else if (handshake) begin
          state_next = HOLD;
          dec_next   = OUT_W'(onehot(32'(sel)));
          valid_next = 1'b1;
          idx_next   = sel;
          hold_next  = HC_W'(HOLD_CYC - 1);
        end
      end

      HOLD: begin
        if (en) begin
          if (hold_reg == '0) begin
            state_next = IDLE;
            dec_next   = '0;
            valid_next = 1'b0;
          end else begin
            hold_next = hold_reg - 1'b1;
          end
        end
      end

      SCAN: begin
        if (!mode) begin
          state_next = IDLE;
          dec_next   = '0;
          valid_next = 1'b0;
          idx_next   = '0;
          pre_clear  = 1'b1;
        end else begin
          pre_en = en;
          if (pre_step) begin
            idx_next  = idx_reg + 1'b1;
            dec_next  = {dec_reg[OUT_W-2:0], dec_reg[OUT_W-1]};
            wrap_next = (idx_reg == SEL_W'(OUT_W - 1));
          end
        end
      end

      default: begin
        state_next = IDLE;
        dec_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      dec_reg   <= '0;
      valid_reg <= 1'b0;
      idx_reg   <= '0;
      hold_reg  <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dec_reg   <= dec_next;
      valid_reg <= valid_next;
      idx_reg   <= idx_next;
      hold_reg  <= hold_next;
      wrap_reg  <= wrap_next;
    end
  end

`ifdef SEQ_DECODER_ACTIVE_LOW_EN
  assign dec_out = ~dec_reg;
`else
  assign dec_out = dec_reg;
`endif
  assign out_valid = valid_reg;
  assign cur_idx   = idx_reg;
  assign wrap      = wrap_reg;

endmodule

// File: tb/tb_seq_decoder_scan.sv
// Directed bench for seq_decoder_scan (SEL_W=3, HOLD_CYC=2, SCAN_DIV=3):
// reset, direct decodes, scan walk with freeze, and conflict cases.
module tb_seq_decoder_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic [7:0] dec_out;
  logic       out_valid;
  logic [2:0] cur_idx;
  logic       wrap;

  int n_checks = 0;
  int n_fail   = 0;

  seq_decoder_scan #(
    .SEL_W   (3),
    .HOLD_CYC(2),
    .SCAN_DIV(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .dec_out  (dec_out),
    .out_valid(out_valid),
    .cur_idx  (cur_idx),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Expected dec_out pin value for an active-high decode pattern.
  function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef SEQ_DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; leaves it idle one negedge after release.
  task automatic direct_decode(input logic [2:0] s);
    logic [7:0] exp_hot;
    exp_hot = 8'h01 << s;
    check_val("idle_ready", 32'(in_ready), 32'd1);
    sel      = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("hold1_dec", 32'(dec_out), 32'(pol(exp_hot)));
    check_val("hold1_idx", 32'(cur_idx), 32'(s));
    check_val("hold1_valid", 32'(out_valid), 32'd1);
    check_val("hold1_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_val("hold2_dec", 32'(dec_out), 32'(pol(exp_hot)));
    check_val("hold2_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_val("release_dec", 32'(dec_out), 32'(pol(8'h00)));
    check_val("release_valid", 32'(out_valid), 32'd0);
    check_val("release_idx", 32'(cur_idx), 32'(s));
    $display("direct sel=%0d dec=0x%02h held 2 cycles", s, pol(exp_hot));
  endtask

  initial begin
    int         k;
    logic       wrap_exp;
    logic [2:0] idx_exp;

    // Reset with random inputs
    rst      = 1'b1;
    en       = 1'($urandom_range(0, 1));
    mode     = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1));
    sel      = 3'($urandom_range(0, 7));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("rst_dec", 32'(dec_out), 32'(pol(8'h00)));
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_idx", 32'(cur_idx), 32'd0);
      check_val("rst_wrap", 32'(wrap), 32'd0);
      check_val("rst_ready", 32'(in_ready), 32'd0);
      en       = 1'($urandom_range(0, 1));
      mode     = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      sel      = 3'($urandom_range(0, 7));
    end
    $display("reset: outputs at reset values");

    rst      = 1'b0;
    en       = 1'b1;
    mode     = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    // Direct decodes
    direct_decode(3'd5);
    for (int s = 0; s < 8; s++) direct_decode(3'(s));

    // en low in IDLE blocks handshakes
    en = 1'b0;
    #1;
    check_val("en_low_ready", 32'(in_ready), 32'd0);
    en = 1'b1;

    // Scan entry with a simultaneous request: scan wins
    mode     = 1'b1;
    in_valid = 1'b1;
    sel      = 3'd6;
    #1;
    check_val("conflict_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    $display("scan entered with conflicting request, dec=0x%02h", dec_out);

    // Scan walk; en dropped for 5 cycles while 0x08 is mid-period
    k        = 0;
    wrap_exp = 1'b0;
    for (int t = 0; t < 40; t++) begin
      idx_exp = 3'((k / 3) % 8);
      check_val("scan_dec", 32'(dec_out), 32'(pol(8'h01 << idx_exp)));
      check_val("scan_idx", 32'(cur_idx), 32'(idx_exp));
      check_val("scan_wrap", 32'(wrap), 32'(wrap_exp));
      check_val("scan_valid", 32'(out_valid), 32'd1);
      $display("scan t=%0d en=%0b dec=0x%02h idx=%0d wrap=%0b", t, en, dec_out, cur_idx, wrap);
      en = !(t >= 10 && t < 15);
      @(negedge clk);
      if (en) begin
        k++;
        wrap_exp = (k % 3 == 0) && ((k / 3) % 8 == 0);
      end else begin
        wrap_exp = 1'b0;
      end
    end
    en = 1'b1;

    // Leave scan
    mode = 1'b0;
    @(negedge clk);
    check_val("scan_exit_dec", 32'(dec_out), 32'(pol(8'h00)));
    check_val("scan_exit_valid", 32'(out_valid), 32'd0);
    check_val("scan_exit_idx", 32'(cur_idx), 32'd0);
    check_val("scan_exit_ready", 32'(in_ready), 32'd1);
    $display("scan exit: dec=0x%02h", dec_out);

    // Reset in the middle of a HOLD of sel=3
    sel      = 3'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("midhold_dec", 32'(dec_out), 32'(pol(8'h08)));
    rst = 1'b1;
    @(negedge clk);
    check_val("midhold_rst_dec", 32'(dec_out), 32'(pol(8'h00)));
    check_val("midhold_rst_valid", 32'(out_valid), 32'd0);
    check_val("midhold_rst_idx", 32'(cur_idx), 32'd0);
    check_val("midhold_rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_val("post_rst_ready", 32'(in_ready), 32'd1);
    $display("reset during HOLD: dec=0x%02h", dec_out);

    // Reset coincident with a request drops it
    sel      = 3'd7;
    in_valid = 1'b1;
    rst      = 1'b1;
    #1;
    check_val("rst_req_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    check_val("rst_req_dec", 32'(dec_out), 32'(pol(8'h00)));
    check_val("rst_req_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_val("rst_req_dec2", 32'(dec_out), 32'(pol(8'h00)));
    $display("reset with request: request dropped, dec=0x%02h", dec_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
